// File: rtl/lorenz_dda_core_pkg.sv
// -----------------------------------------------------------------------------
// lorenz_dda_core_pkg
// Shared definitions for the Lorenz Euler integrator:
//   - datapath width and fractional bits (signed Q8.8)
//   - saturation limits
//   - coefficient / initial-condition register indices
//   - integrator FSM state encoding
//   - saturating add/subtract helpers used by the top level
// -----------------------------------------------------------------------------
package lorenz_dda_core_pkg;

  localparam int N    = 16;
  localparam int FRAC = 8;

  localparam logic signed [N-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [N-1:0] SAT_MIN = 16'sh8000;

  // Register index = addr[3:1]; index 7 is not backed by storage.
  localparam logic [2:0] REG_ICX   = 3'd0;
  localparam logic [2:0] REG_ICY   = 3'd1;
  localparam logic [2:0] REG_ICZ   = 3'd2;
  localparam logic [2:0] REG_SIGMA = 3'd3;
  localparam logic [2:0] REG_BETA  = 3'd4;
  localparam logic [2:0] REG_RHO   = 3'd5;
  localparam logic [2:0] REG_DT    = 3'd6;
  localparam int         NUM_REGS  = 7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_M4,
    ST_M5,
    ST_M6,
    ST_M7,
    ST_UPD
  } state_t;

  // Clamp an (N+1)-bit intermediate back into N bits. An overflow shows up
  // as the two top bits disagreeing; the true sign is the topmost bit.
  function automatic logic signed [N-1:0] satNarrow(input logic signed [N:0] v);
    if (v[N] != v[N-1]) begin
      return v[N] ? SAT_MIN : SAT_MAX;
    end
    return v[N-1:0];
  endfunction

  function automatic logic signed [N-1:0] satAdd(input logic signed [N-1:0] a,
                                                 input logic signed [N-1:0] b);
    return satNarrow({a[N-1], a} + {b[N-1], b});
  endfunction

  function automatic logic signed [N-1:0] satSub(input logic signed [N-1:0] a,
                                                 input logic signed [N-1:0] b);
    return satNarrow({a[N-1], a} - {b[N-1], b});
  endfunction

endpackage

// File: rtl/lorenz_dda_core_fxmul.sv
// -----------------------------------------------------------------------------
// dda_fxmul
// Signed fixed-point multiplier: full product, arithmetic shift right by FRAC
// (floor rounding), then saturation into the signed N-bit range.
// Ports:
//   a_i  in  N  signed multiplicand
//   b_i  in  N  signed multiplier
//   p_o  out N  saturated Q-format product
// -----------------------------------------------------------------------------
module dda_fxmul
  import lorenz_dda_core_pkg::*;
(
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] b_i,
  output logic signed [N-1:0] p_o
);

  logic signed [2*N-1:0] product;
  logic signed [2*N-1:0] scaled;
  logic                  fits;

  // The shifted product fits in N bits only when every bit from the N-bit
  // sign position upward is a copy of the sign; otherwise clamp by sign.
  always_comb begin
    product = a_i * b_i;
    scaled  = product >>> FRAC;
    fits    = (&scaled[2*N-1:N-1]) | (~|scaled[2*N-1:N-1]);
    if (fits) begin
      p_o = scaled[N-1:0];
    end else begin
      p_o = scaled[2*N-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/lorenz_dda_core.sv
// -----------------------------------------------------------------------------
// lorenz_dda_core
// Fixed-point (Q8.8) Euler integrator for the Lorenz system in the TinyTapeout
// user-project pinout. Coefficients and initial conditions are written
// byte-wise; while run is high one Euler step completes every 8 clocks using
// a single shared multiplier.
// Ports:
//   clk      in   1  clock
//   rst      in   1  synchronous active-high reset
//   ena      in   1  clock enable, 0 freezes all state
//   ui_in    in   8  write data byte
//   uio_in   in   8  [3:0] addr, [4] wr, [5] run, [7:6] out_sel
//   uo_out   out  8  x/y/z high byte or step counter
//   uio_out  out  8  constant 0
//   uio_oe   out  8  constant 0 (uio pins are inputs)
// -----------------------------------------------------------------------------
module lorenz_dda_core
  import lorenz_dda_core_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0] addr;
  logic       wr;
  logic       run;
  logic [1:0] outSel;

  logic [N-1:0] regFile_q [NUM_REGS];
  logic signed [N-1:0] icx, icy, icz, sigma, beta, rho, dt;

  logic signed [N-1:0] x_q, y_q, z_q;
  logic signed [N-1:0] p_q, q_q, dx_q, dy_q, dz_q;
  logic [7:0]          stepCnt_q;

  state_t state_q, state_d;

  logic signed [N-1:0] mulA, mulB, mulP;

  assign addr   = uio_in[3:0];
  assign wr     = uio_in[4];
  assign run    = uio_in[5];
  assign outSel = uio_in[7:6];

  assign icx   = regFile_q[REG_ICX];
  assign icy   = regFile_q[REG_ICY];
  assign icz   = regFile_q[REG_ICZ];
  assign sigma = regFile_q[REG_SIGMA];
  assign beta  = regFile_q[REG_BETA];
  assign rho   = regFile_q[REG_RHO];
  assign dt    = regFile_q[REG_DT];

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  // Register file: level-sensitive byte writes every enabled clock while wr
  // is high. Index 7 has no storage so those writes simply fall away.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (ena && wr && (addr[3:1] != 3'd7)) begin
      if (addr[0]) begin
        regFile_q[addr[3:1]][15:8] <= ui_in;
      end else begin
        regFile_q[addr[3:1]][7:0] <= ui_in;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state logic: dropping run always returns to IDLE, which is what
  // aborts a step in flight; otherwise walk M1..M7, UPD and loop.
  always_comb begin
    state_d = state_q;
    if (!run) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_M1;
        ST_M1:   state_d = ST_M2;
        ST_M2:   state_d = ST_M3;
        ST_M3:   state_d = ST_M4;
        ST_M4:   state_d = ST_M5;
        ST_M5:   state_d = ST_M6;
        ST_M6:   state_d = ST_M7;
        ST_M7:   state_d = ST_UPD;
        ST_UPD:  state_d = ST_M1;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Operand steering for the shared multiplier. Coefficients are read live
  // from the register file so writes during a run land on the next use.
  always_comb begin
    mulA = '0;
    mulB = '0;
    case (state_q)
      ST_M1: begin mulA = sigma; mulB = satSub(y_q, x_q);  end
      ST_M2: begin mulA = dt;    mulB = p_q;               end
      ST_M3: begin mulA = x_q;   mulB = satSub(rho, z_q);  end
      ST_M4: begin mulA = dt;    mulB = satSub(p_q, y_q);  end
      ST_M5: begin mulA = x_q;   mulB = y_q;               end
      ST_M6: begin mulA = beta;  mulB = z_q;               end
      ST_M7: begin mulA = dt;    mulB = satSub(p_q, q_q);  end
      default: ;
    endcase
  end

  dda_fxmul uMul (
    .a_i (mulA),
    .b_i (mulB),
    .p_o (mulP)
  );

  // Integrator datapath. Whenever run is low (or we are just leaving IDLE)
  // the state reloads from the initial conditions; the UPD commit is
  // skipped if run has already fallen, so no partial step is ever applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      p_q       <= '0;
      q_q       <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      dz_q      <= '0;
      stepCnt_q <= '0;
    end else if (ena) begin
      if (!run || (state_q == ST_IDLE)) begin
        x_q       <= icx;
        y_q       <= icy;
        z_q       <= icz;
        stepCnt_q <= '0;
      end else begin
        case (state_q)
          ST_M1: p_q  <= mulP;
          ST_M2: dx_q <= mulP;
          ST_M3: p_q  <= mulP;
          ST_M4: dy_q <= mulP;
          ST_M5: p_q  <= mulP;
          ST_M6: q_q  <= mulP;
          ST_M7: dz_q <= mulP;
          ST_UPD: begin
            x_q       <= satAdd(x_q, dx_q);
            y_q       <= satAdd(y_q, dy_q);
            z_q       <= satAdd(z_q, dz_q);
            stepCnt_q <= stepCnt_q + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Output byte selection straight from the state registers.
  always_comb begin
    uo_out = 8'h00;
    case (outSel)
      2'b00: uo_out = x_q[15:8];
      2'b01: uo_out = y_q[15:8];
      2'b10: uo_out = z_q[15:8];
      default: uo_out = stepCnt_q;
    endcase
  end

endmodule

// File: tb/tb_lorenz_dda_core.sv
// -----------------------------------------------------------------------------
// tb_lorenz_dda_core
// Self-checking bench for lorenz_dda_core. Expected output bytes are pushed
// into a queue when the stimulus is set up and popped when the DUT output is
// read. Multi-step expectations come from an independent integer model of the
// saturating Q8.8 Euler step.
// -----------------------------------------------------------------------------
module tb_lorenz_dda_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [3:0] addr;
  logic       wr;
  logic       run;
  logic [1:0] outSel;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;

  logic [7:0] expQ [$];
  logic [7:0] expByte;

  logic signed [15:0] mx, my, mz;
  logic signed [15:0] mSigma, mRho, mBeta, mDt;
  logic [7:0]         mCnt;

  assign uio_in = {outSel, run, wr, addr};

  // Free-running clock, 20 time units per period.
  always #10 clk = ~clk;

  lorenz_dda_core dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Reference arithmetic: exact integer math, then clamp to 16-bit signed.
  function automatic logic signed [15:0] mSat(input longint v);
    if (v > 32767)  return 16'sh7FFF;
    if (v < -32768) return 16'sh8000;
    return 16'(v);
  endfunction

  function automatic logic signed [15:0] mMul(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    longint pr;
    pr = longint'(a) * longint'(b);
    return mSat(pr >>> 8);
  endfunction

  function automatic logic signed [15:0] mAdd(input logic signed [15:0] a,
                                              input logic signed [15:0] b);
    return mSat(longint'(a) + longint'(b));
  endfunction

  function automatic logic signed [15:0] mSubF(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    return mSat(longint'(a) - longint'(b));
  endfunction

  // One Euler step of the model.
  task automatic modelStep();
    logic signed [15:0] p, q, dx, dy, dz;
    p  = mMul(mSigma, mSubF(my, mx));
    dx = mMul(mDt, p);
    p  = mMul(mx, mSubF(mRho, mz));
    dy = mMul(mDt, mSubF(p, my));
    p  = mMul(mx, my);
    q  = mMul(mBeta, mz);
    dz = mMul(mDt, mSubF(p, q));
    mx = mAdd(mx, dx);
    my = mAdd(my, dy);
    mz = mAdd(mz, dz);
    mCnt = mCnt + 8'd1;
  endtask

  task automatic pushModel();
    expQ.push_back(mx[15:8]);
    expQ.push_back(my[15:8]);
    expQ.push_back(mz[15:8]);
    expQ.push_back(mCnt);
  endtask

  task automatic pushBytes(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    expQ.push_back(b0);
    expQ.push_back(b1);
    expQ.push_back(b2);
    expQ.push_back(b3);
  endtask

  task automatic writeReg(input logic [2:0] r, input logic [15:0] v);
    @(negedge clk);
    addr  = {r, 1'b0};
    ui_in = v[7:0];
    wr    = 1'b1;
    @(negedge clk);
    addr  = {r, 1'b1};
    ui_in = v[15:8];
    @(negedge clk);
    wr    = 1'b0;
  endtask

  // Loads every register with run low, waits for the reload, seeds the model.
  task automatic loadAll(input logic [15:0] sg, input logic [15:0] rh,
                         input logic [15:0] bt, input logic [15:0] dtv,
                         input logic [15:0] ix, input logic [15:0] iy,
                         input logic [15:0] iz);
    run = 1'b0;
    writeReg(3'd3, sg);
    writeReg(3'd5, rh);
    writeReg(3'd4, bt);
    writeReg(3'd6, dtv);
    writeReg(3'd0, ix);
    writeReg(3'd1, iy);
    writeReg(3'd2, iz);
    @(posedge clk);
    @(negedge clk);
    mSigma = sg; mRho = rh; mBeta = bt; mDt = dtv;
    mx = ix; my = iy; mz = iz; mCnt = 8'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; run = 1'b0; wr = 1'b0;
    addr = 4'h0; ui_in = 8'h00; outSel = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    pushBytes(8'h00, 8'h00, 8'h00, 8'h00);
    for (int s = 0; s < 4; s++) begin
      outSel = 2'(s);
      #1;
      expByte = expQ.pop_front();
      checks++;
      if (uo_out !== expByte) begin
        errors++;
        $display("[TB] FAIL reset sel=%0d got=%02h want=%02h", s, uo_out, expByte);
      end
    end
    checks++;
    if ((uio_out !== 8'h00) || (uio_oe !== 8'h00)) begin
      errors++;
      $display("[TB] FAIL uio_tie got out=%02h oe=%02h want 00/00", uio_out, uio_oe);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    writeReg(3'd0, 16'h0100);
    @(posedge clk);
    @(negedge clk);
    pushBytes(8'h01, 8'h00, 8'h00, 8'h00);
    for (int s = 0; s < 4; s++) begin
      outSel = 2'(s);
      #1;
      expByte = expQ.pop_front();
      checks++;
      if (uo_out !== expByte) begin
        errors++;
        $display("[TB] FAIL load sel=%0d got=%02h want=%02h", s, uo_out, expByte);
      end
    end
  endtask

  task automatic test_step();
    loadAll(16'h0A00, 16'h1C00, 16'h02AB, 16'h0004, 16'h0100, 16'h0100, 16'h0100);
    run = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    // x=0x0100, y=0x0168, z=0x00F9, step_cnt=1
    pushBytes(8'h01, 8'h01, 8'h00, 8'h01);
    for (int s = 0; s < 4; s++) begin
      outSel = 2'(s);
      #1;
      expByte = expQ.pop_front();
      checks++;
      if (uo_out !== expByte) begin
        errors++;
        $display("[TB] FAIL step sel=%0d got=%02h want=%02h", s, uo_out, expByte);
      end
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_saturation();
    loadAll(16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h7F00, 16'h0000);
    run = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    // x clamps to 0x7FFF, y = 0x7F00 + 0x8000 = 0xFF00, z stays 0
    pushBytes(8'h7F, 8'hFF, 8'h00, 8'h01);
    for (int s = 0; s < 4; s++) begin
      outSel = 2'(s);
      #1;
      expByte = expQ.pop_front();
      checks++;
      if (uo_out !== expByte) begin
        errors++;
        $display("[TB] FAIL saturation sel=%0d got=%02h want=%02h", s, uo_out, expByte);
      end
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    loadAll(16'h0A00, 16'h1C00, 16'h02AB, 16'h0008, 16'h0100, 16'h0100, 16'h0100);
    run = 1'b1;
    repeat (25) @(posedge clk);
    @(negedge clk);
    modelStep(); modelStep(); modelStep();
    pushModel();
    for (int s = 0; s < 4; s++) begin
      outSel = 2'(s);
      #1;
      expByte = expQ.pop_front();
      checks++;
      if (uo_out !== expByte) begin
        errors++;
        $display("[TB] FAIL abort_pre sel=%0d got=%02h want=%02h", s, uo_out, expByte);
      end
    end
    // Finish M1..M4 of the fourth step, then drop run.
    repeat (4) @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    @(negedge clk);
    pushBytes(8'h01, 8'h01, 8'h01, 8'h00);
    for (int s = 0; s < 4; s++) begin
      outSel = 2'(s);
      #1;
      expByte = expQ.pop_front();
      checks++;
      if (uo_out !== expByte) begin
        errors++;
        $display("[TB] FAIL abort sel=%0d got=%02h want=%02h", s, uo_out, expByte);
      end
    end
  endtask

  task automatic test_hold();
    loadAll(16'h0A00, 16'h1C00, 16'h02AB, 16'h0008, 16'h0100, 16'h0100, 16'h0100);
    run = 1'b1;
    repeat (9) @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    modelStep();
    // Freeze mid-step; a write attempt to dt must also be ignored.
    ena   = 1'b0;
    addr  = 4'hC;
    ui_in = 8'hFF;
    wr    = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    pushModel();
    for (int s = 0; s < 4; s++) begin
      outSel = 2'(s);
      #1;
      expByte = expQ.pop_front();
      checks++;
      if (uo_out !== expByte) begin
        errors++;
        $display("[TB] FAIL hold sel=%0d got=%02h want=%02h", s, uo_out, expByte);
      end
    end
    wr  = 1'b0;
    ena = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    pushModel();
    for (int s = 0; s < 4; s++) begin
      outSel = 2'(s);
      #1;
      expByte = expQ.pop_front();
      checks++;
      if (uo_out !== expByte) begin
        errors++;
        $display("[TB] FAIL resume_early sel=%0d got=%02h want=%02h", s, uo_out, expByte);
      end
    end
    @(posedge clk);
    @(negedge clk);
    modelStep();
    pushModel();
    for (int s = 0; s < 4; s++) begin
      outSel = 2'(s);
      #1;
      expByte = expQ.pop_front();
      checks++;
      if (uo_out !== expByte) begin
        errors++;
        $display("[TB] FAIL resume sel=%0d got=%02h want=%02h", s, uo_out, expByte);
      end
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    loadAll(16'h0A00, 16'h1C00, 16'h02AB, 16'h0008, 16'h0100, 16'h0100, 16'h0100);
    run = 1'b1;
    for (int k = 0; k < 260; k++) begin
      repeat ((k == 0) ? 9 : 8) @(posedge clk);
      @(negedge clk);
      modelStep();
      pushModel();
      for (int s = 0; s < 4; s++) begin
        outSel = 2'(s);
        #1;
        expByte = expQ.pop_front();
        checks++;
        if (uo_out !== expByte) begin
          errors++;
          $display("[TB] FAIL b2b step=%0d sel=%0d got=%02h want=%02h",
                   k + 1, s, uo_out, expByte);
        end
      end
    end
    run = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load();
    test_step();
    test_saturation();
    test_abort();
    test_hold();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
